booth4_mul: RTL and testbench

Iterative radix-4 (modified Booth) multiplier. It is the parametrised successor of the team's radix-2 sequential Booth multiplier. It retires two multiplier bits per cycle, supports signed and unsigned operands per operation, and uses valid/ready handshakes on both its input and output sides. It sits in the datapath as a multi-cycle functional unit behind an issue stage and feeds a result queue that may apply backpressure.

---
 rtl/booth4_mul.sv | 147 ++++++++++++++
 tb/tb_booth4_mul.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth4_mul.sv
// Iterative radix-4 (modified Booth) multiplier with valid/ready handshakes.
// Retires two multiplier bits per cycle; signed or unsigned operands per operation.
module booth4_mul #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   z,
   output logic                 busy
);

   localparam int E  = WIDTH + 2;
   localparam int N  = E / 2;
   localparam int AW = E + 2;
   localparam int MW = E + 1;
   localparam int TW = AW + MW;
   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
         $error("booth4_mul: WIDTH must be even and >= 4");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE = 3'b001,
      CALC = 3'b010,
      DONE = 3'b100
   } state_t;

   state_t state;
   state_t state_next;

   logic [E-1:0]          xr;
   logic [AW-1:0]         acc;
   logic [MW-1:0]         mreg;
   logic [CW-1:0]         cnt;
   logic [E-1:0]          x_ext;
   logic [E-1:0]          y_ext;
   logic [AW-1:0]         addend;
   logic [AW-1:0]         acc_sum;
   logic signed [TW-1:0]  shifted;
   logic                  last;

   assign last      = (cnt == LAST);
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == CALC) || (state == DONE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode; unknown encodings fall back to IDLE
   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE: begin
            if (in_valid) state_next = CALC;
            else          state_next = IDLE;
         end
         CALC: begin
            if (last) state_next = DONE;
            else      state_next = CALC;
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
            else           state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand extension to E bits according to the requested mode
   always_comb begin
      if (is_signed) begin
         x_ext = {{2{x[WIDTH-1]}}, x};
         y_ext = {{2{y[WIDTH-1]}}, y};
      end else begin
         x_ext = {2'b00, x};
         y_ext = {2'b00, y};
      end
   end

   // Booth digit recoding of the low 3-bit window of the multiplier
   always_comb begin
      addend = {AW{1'b0}};
      case (mreg[2:0])
         3'b001, 3'b010: addend = {{2{xr[E-1]}}, xr};
         3'b011:         addend = {xr[E-1], xr, 1'b0};
         3'b100:         addend = -{xr[E-1], xr, 1'b0};
         3'b101, 3'b110: addend = -{{2{xr[E-1]}}, xr};
         default:        addend = {AW{1'b0}};
      endcase
   end

   assign acc_sum = acc + addend;
   // After the final shift the product sits one bit above the bottom of the register
   assign shifted = $signed({acc_sum, mreg}) >>> 2'd2;

   // Datapath: capture in IDLE, iterate in CALC, latch product on the last step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xr   <= {E{1'b0}};
         acc  <= {AW{1'b0}};
         mreg <= {MW{1'b0}};
         cnt  <= {CW{1'b0}};
         z    <= {(2*WIDTH){1'b0}};
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  xr   <= x_ext;
                  acc  <= {AW{1'b0}};
                  mreg <= {y_ext, 1'b0};
                  cnt  <= {CW{1'b0}};
               end
            end
            CALC: begin
               acc  <= shifted[TW-1:MW];
               mreg <= shifted[MW-1:0];
               cnt  <= cnt + CW'(1);
               if (last) begin
                  z <= shifted[2*WIDTH:1];
               end
            end
            default: begin
               cnt <= cnt;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth4_mul.sv
// Self-checking bench for booth4_mul at WIDTH 8, 16 and 32 against a
// transaction-level model (exact product, N+1 latency, ready/valid rules).
module tb_booth4_mul;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int wv[3] = '{8, 16, 32};
   int nv[3] = '{5, 9, 17};

   logic        iv[3];
   logic        isg[3];
   logic        ordy[3];
   logic [31:0] xin[3];
   logic [31:0] yin[3];

   logic        ir0, ir1, ir2, ov0, ov1, ov2, bs0, bs1, bs2;
   logic [15:0] z8;
   logic [31:0] z16;
   logic [63:0] z32;

   logic        dir[3];
   logic        dov[3];
   logic        dbusy[3];
   logic [63:0] dz[3];

   assign dir[0] = ir0;
   assign dir[1] = ir1;
   assign dir[2] = ir2;
   assign dov[0] = ov0;
   assign dov[1] = ov1;
   assign dov[2] = ov2;
   assign dbusy[0] = bs0;
   assign dbusy[1] = bs1;
   assign dbusy[2] = bs2;
   assign dz[0] = {48'd0, z8};
   assign dz[1] = {32'd0, z16};
   assign dz[2] = z32;

   booth4_mul #(.WIDTH(8)) u_mul8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
      .x(xin[0][7:0]), .y(yin[0][7:0]), .is_signed(isg[0]),
      .out_valid(ov0), .out_ready(ordy[0]), .z(z8), .busy(bs0));

   booth4_mul #(.WIDTH(16)) u_mul16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
      .x(xin[1][15:0]), .y(yin[1][15:0]), .is_signed(isg[1]),
      .out_valid(ov1), .out_ready(ordy[1]), .z(z16), .busy(bs1));

   booth4_mul #(.WIDTH(32)) u_mul32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2),
      .x(xin[2]), .y(yin[2]), .is_signed(isg[2]),
      .out_valid(ov2), .out_ready(ordy[2]), .z(z32), .busy(bs2));

   int nvec = 0;
   int nmis = 0;

   bit          pend[3];
   int          age[3];
   logic [63:0] ez[3];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Exact product of w-bit operands, truncated to 2w bits
   function automatic logic [63:0] ref_prod(input int w, input bit s,
                                            input logic [63:0] a, input logic [63:0] b);
      logic [63:0] ea;
      logic [63:0] eb;
      for (int i = 0; i < 64; i++) begin
         ea[i] = (i < w) ? a[i] : (s & a[w-1]);
         eb[i] = (i < w) ? b[i] : (s & b[w-1]);
      end
      return (ea * eb) & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   function automatic logic [31:0] rnd_op(input int w);
      logic [31:0] m;
      m = (32'd1 << w) - 32'd1;
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return m;
         3:       return m >> 1;
         4:       return (m >> 1) + 32'd1;
         default: return $urandom() & m;
      endcase
   endfunction

   // Compare process: check outputs, then predict the effect of the next edge
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         bit ove;
         if (!rst_n) begin
            pend[k] = 1'b0;
            age[k]  = 0;
            chk($sformatf("rst_in_ready_w%0d", wv[k]), 64'(dir[k]), 64'd1);
            chk($sformatf("rst_out_valid_w%0d", wv[k]), 64'(dov[k]), 64'd0);
            chk($sformatf("rst_busy_w%0d", wv[k]), 64'(dbusy[k]), 64'd0);
            chk($sformatf("rst_z_w%0d", wv[k]), dz[k], 64'd0);
         end else begin
            ove = pend[k] && (age[k] >= nv[k]);
            chk($sformatf("in_ready_w%0d", wv[k]), 64'(dir[k]), 64'(!pend[k]));
            chk($sformatf("busy_w%0d", wv[k]), 64'(dbusy[k]), 64'(pend[k]));
            chk($sformatf("out_valid_w%0d", wv[k]), 64'(dov[k]), 64'(ove));
            if (ove) chk($sformatf("z_w%0d", wv[k]), dz[k], ez[k]);
            if (pend[k]) begin
               if (ove && ordy[k]) pend[k] = 1'b0;
               else                age[k]  = age[k] + 1;
            end else if (iv[k]) begin
               pend[k] = 1'b1;
               age[k]  = 0;
               ez[k]   = ref_prod(wv[k], isg[k], 64'(xin[k]), 64'(yin[k]));
            end
         end
      end
   end

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                        input logic [63:0] lit, input string nm);
      int n;
      @(posedge clk); #1;
      iv[0] = 1'b1; xin[0] = a; yin[0] = b; isg[0] = s; ordy[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ov0 && n < 40);
      if (!ov0) begin
         nvec++; nmis++;
         $display("FAIL %s_timeout: out_valid 0 after 40 cycles, expected 1", nm);
      end else begin
         chk({nm, "_latency"}, 64'(n), 64'd6);
         chk(nm, dz[0], lit);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_valid(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ov0 && n < 40);
      if (!ov0) begin
         nvec++; nmis++;
         $display("FAIL %s_timeout: out_valid 0 after 40 cycles, expected 1", nm);
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b0; isg[k] = 1'b0; ordy[k] = 1'b1; xin[k] = 32'd0; yin[k] = 32'd0;
      end

      // Model pinned to hand-computed products
      chk("pin_min_sq8", ref_prod(8, 1'b1, 64'h80, 64'h80), 64'h4000);
      chk("pin_m1x127", ref_prod(8, 1'b1, 64'hFF, 64'h7F), 64'hFF81);
      chk("pin_u255sq", ref_prod(8, 1'b0, 64'hFF, 64'hFF), 64'hFE01);
      chk("pin_s255sq", ref_prod(8, 1'b1, 64'hFF, 64'hFF), 64'h0001);
      chk("pin_3xm5", ref_prod(8, 1'b1, 64'h03, 64'hFB), 64'hFFF1);
      chk("pin_u16max", ref_prod(16, 1'b0, 64'hFFFF, 64'hFFFF), 64'hFFFE0001);
      chk("pin_min_sq32", ref_prod(32, 1'b1, 64'h80000000, 64'h80000000), 64'h4000000000000000);

      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      do_op(32'h80, 32'h80, 1'b1, 64'h4000, "min_sq");
      do_op(32'hFF, 32'h7F, 1'b1, 64'hFF81, "m1x127");
      do_op(32'hFF, 32'hFF, 1'b0, 64'hFE01, "u255sq");
      do_op(32'hFF, 32'hFF, 1'b1, 64'h0001, "s255sq");

      // Backpressure: result held while out_ready is low
      @(posedge clk); #1;
      iv[0] = 1'b1; xin[0] = 32'h03; yin[0] = 32'hFB; isg[0] = 1'b1; ordy[0] = 1'b0;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      wait_valid("bp");
      chk("bp_z", dz[0], 64'hFFF1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("bp_z_hold", dz[0], 64'hFFF1);
         chk("bp_valid_hold", 64'(ov0), 64'd1);
         chk("bp_in_ready_low", 64'(ir0), 64'd0);
      end
      @(posedge clk); #1;
      ordy[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_idle_after", 64'(ir0), 64'd1);

      // Inputs changing during CALC must be ignored
      @(posedge clk); #1;
      iv[0] = 1'b1; xin[0] = 32'h07; yin[0] = 32'h09; isg[0] = 1'b1; ordy[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         xin[0] = $urandom(); yin[0] = $urandom(); isg[0] = ~isg[0];
         iv[0] = (c == 1);
      end
      iv[0] = 1'b0;
      wait_valid("ign");
      chk("ign_z", dz[0], 64'd63);
      @(posedge clk); #1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("ign_no_second", 64'(ov0), 64'd0);
      end

      // Reset during CALC cycle 3
      @(posedge clk); #1;
      iv[0] = 1'b1; xin[0] = 32'h55; yin[0] = 32'h33; isg[0] = 1'b0;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(ov0), 64'd0);
      chk("mid_rst_z", dz[0], 64'd0);
      chk("mid_rst_in_ready", 64'(ir0), 64'd1);
      chk("mid_rst_busy", 64'(bs0), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_op(32'h55, 32'h33, 1'b0, 64'h10EF, "after_rst");

      // Random regression on all three widths
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++) begin
            iv[k]   = ($urandom_range(0, 1) == 1);
            xin[k]  = rnd_op(wv[k]);
            yin[k]  = rnd_op(wv[k]);
            isg[k]  = 1'($urandom_range(0, 1));
            ordy[k] = ($urandom_range(0, 3) != 0);
         end
      end
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b1;
      end
      repeat (40) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
